// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with byte-enabled writes, registered reads,
// write-to-read bypass and a hardware clear sequencer that zeroes the array.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | normal operation: writes and reads accepted, clr sampled
// S_CLEAR | zeroing entry[ptr] each cycle; ports locked out, busy=1
module regfile_2r1w #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               EN,
    input  logic               write,
    input  logic [AW-1:0]      selin,
    input  logic [WIDTH-1:0]   inp,
    input  logic [WIDTH/8-1:0] be,
    input  logic               read0,
    input  logic [AW-1:0]      selout0,
    output logic [WIDTH-1:0]   out0,
    output logic               valid0,
    input  logic               read1,
    input  logic [AW-1:0]      selout1,
    output logic [WIDTH-1:0]   out1,
    output logic               valid1,
    input  logic               clr,
    output logic               busy
);

    localparam int NB = WIDTH / 8;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;
    localparam logic [AW:0] PTR_LAST = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] DEPTH_W  = (AW + 1)'(DEPTH);

    logic [0:0]       state_q, state_d;
    logic [AW:0]      ptr_q, ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] out0_q, out0_d, out1_q, out1_d;
    logic             valid0_q, valid0_d, valid1_q, valid1_d;

    logic             idle;
    logic             wr_en;
    logic [WIDTH-1:0] wr_old, wr_word;
    logic [WIDTH-1:0] rd0_data, rd1_data;

    // Addresses past DEPTH and the hardwired zero entry are neither written nor read.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign idle  = (state_q == S_IDLE);
    assign wr_en = idle && EN && write && addr_ok(selin);

    always_comb begin
        wr_old  = addr_ok(selin) ? mem_q[selin] : '0;
        wr_word = wr_old;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) wr_word[8*k +: 8] = inp[8*k +: 8];
        end
    end

    always_comb begin
        rd0_data = '0;
        if (addr_ok(selout0)) rd0_data = (wr_en && selin == selout0) ? wr_word : mem_q[selout0];
        rd1_data = '0;
        if (addr_ok(selout1)) rd1_data = (wr_en && selin == selout1) ? wr_word : mem_q[selout1];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (clr) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                if (ptr_q == PTR_LAST) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        valid0_d = idle && EN && read0;
        valid1_d = idle && EN && read1;
        out0_d   = valid0_d ? rd0_data : out0_q;
        out1_d   = valid1_d ? rd1_data : out1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_CLEAR;
            ptr_q    <= '0;
            out0_q   <= '0;
            out1_q   <= '0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            out0_q   <= out0_d;
            out1_q   <= out1_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
        end
    end

    // The array carries no reset; its contents are defined by the clear sequence.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem_q[ptr_q[AW-1:0]] <= '0;
        end else if (wr_en) begin
            mem_q[selin] <= wr_word;
        end
    end

    assign out0   = out0_q;
    assign out1   = out1_q;
    assign valid0 = valid0_q;
    assign valid1 = valid1_q;
    assign busy   = (state_q == S_CLEAR);

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: a default 32-entry instance and a 20-entry instance share
// stimulus; each is compared every cycle against an array-based reference model.
module tb_regfile_2r1w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, EN, write, read0, read1, clr;
    logic [4:0]  selin, selout0, selout1;
    logic [31:0] inp;
    logic [3:0]  be;

    logic [31:0] a_out0, a_out1, b_out0, b_out1;
    logic        a_valid0, a_valid1, a_busy, b_valid0, b_valid1, b_busy;

    regfile_2r1w u_big (
        .clk(clk), .reset(reset), .EN(EN), .write(write), .selin(selin), .inp(inp), .be(be),
        .read0(read0), .selout0(selout0), .out0(a_out0), .valid0(a_valid0),
        .read1(read1), .selout1(selout1), .out1(a_out1), .valid1(a_valid1),
        .clr(clr), .busy(a_busy)
    );

    regfile_2r1w #(.WIDTH(32), .DEPTH(20), .AW(5), .ZERO_REG(1)) u_small (
        .clk(clk), .reset(reset), .EN(EN), .write(write), .selin(selin), .inp(inp), .be(be),
        .read0(read0), .selout0(selout0), .out0(b_out0), .valid0(b_valid0),
        .read1(read1), .selout1(selout1), .out1(b_out1), .valid1(b_valid1),
        .clr(clr), .busy(b_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: index 0 = 32-entry instance, index 1 = 20-entry instance.
    int          dep [2] = '{32, 20};
    logic [31:0] mdl [2][32];
    int          bcnt [2];
    logic [31:0] e_o0 [2], e_o1 [2];
    logic        e_v0 [2], e_v1 [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            bcnt[m] = dep[m];
            e_o0[m] = '0; e_o1[m] = '0;
            e_v0[m] = 1'b0; e_v1[m] = 1'b0;
            for (int i = 0; i < 32; i++) mdl[m][i] = '0;
        end
    endtask

    function automatic logic [31:0] mread(input int m, input int a);
        return (a < dep[m] && a != 0) ? mdl[m][a] : 32'h0;
    endfunction

    // Applied just before an edge: the write lands first so same-cycle reads see it.
    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            if (bcnt[m] > 0) begin
                bcnt[m]--;
                e_v0[m] = 1'b0;
                e_v1[m] = 1'b0;
            end else begin
                if (EN && write && int'(selin) < dep[m] && selin != 0)
                    for (int k = 0; k < 4; k++)
                        if (be[k]) mdl[m][selin][8*k +: 8] = inp[8*k +: 8];
                e_v0[m] = EN && read0;
                if (e_v0[m]) e_o0[m] = mread(m, int'(selout0));
                e_v1[m] = EN && read1;
                if (e_v1[m]) e_o1[m] = mread(m, int'(selout1));
                if (clr) begin
                    bcnt[m] = dep[m];
                    for (int i = 0; i < 32; i++) mdl[m][i] = '0;
                end
            end
        end
    endtask

    task automatic compare();
        chk("big.out0",   a_out0,           e_o0[0]);
        chk("big.out1",   a_out1,           e_o1[0]);
        chk("big.valid0", 32'(a_valid0),    32'(e_v0[0]));
        chk("big.valid1", 32'(a_valid1),    32'(e_v1[0]));
        chk("big.busy",   32'(a_busy),      32'(bcnt[0] > 0));
        chk("sml.out0",   b_out0,           e_o0[1]);
        chk("sml.out1",   b_out1,           e_o1[1]);
        chk("sml.valid0", 32'(b_valid0),    32'(e_v0[1]));
        chk("sml.valid1", 32'(b_valid1),    32'(e_v1[1]));
        chk("sml.busy",   32'(b_busy),      32'(bcnt[1] > 0));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic set_idle();
        EN = 1'b1; write = 1'b0; read0 = 1'b0; read1 = 1'b0; clr = 1'b0;
        selin = '0; selout0 = '0; selout1 = '0; inp = '0; be = '0;
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        #3 compare();
        chk("reset.busy", 32'(a_busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (34) step();

        for (int i = 0; i < 32; i++) begin
            read0 = 1'b1; selout0 = 5'(i);
            read1 = 1'b1; selout1 = 5'(31 - i);
            step();
            chk("init.zero", a_out0, 32'h0);
        end
        set_idle(); step();

        write = 1'b1; selin = 5'd5; inp = 32'hDEADBEEF; be = 4'b1111; step();
        inp = 32'h00001200; be = 4'b0010; step();
        write = 1'b0; read0 = 1'b1; selout0 = 5'd5; step();
        chk("rmw.data", a_out0, 32'hDEAD12EF);
        set_idle(); step();

        write = 1'b1; selin = 5'd7; inp = 32'hA5A5A5A5; be = 4'b1111;
        read0 = 1'b1; selout0 = 5'd7; read1 = 1'b1; selout1 = 5'd7; step();
        chk("bypass.out0", a_out0, 32'hA5A5A5A5);
        chk("bypass.out1", a_out1, 32'hA5A5A5A5);
        set_idle(); step();

        write = 1'b1; selin = 5'd0; inp = 32'hFFFFFFFF; be = 4'b1111; step();
        write = 1'b0; read0 = 1'b1; selout0 = 5'd0; step();
        chk("zero_reg", a_out0, 32'h0);
        write = 1'b1; selin = 5'd25; inp = 32'h12345678; read0 = 1'b0; step();
        write = 1'b0; read0 = 1'b1; selout0 = 5'd25; step();
        chk("oob.small", b_out0, 32'h0);
        chk("oob.big",   a_out0, 32'h12345678);
        set_idle(); step();

        for (int i = 1; i < 32; i++) begin
            write = 1'b1; selin = 5'(i); inp = 32'h01010101 * 32'(i) ^ 32'h5A000000; be = 4'hF;
            step();
        end
        set_idle(); read0 = 1'b1; selout0 = 5'd3; read1 = 1'b1; selout1 = 5'd9; step();
        set_idle(); clr = 1'b1; step();
        clr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            write = 1'b1; selin = 5'($urandom_range(1, 31)); inp = $urandom; be = 4'hF;
            read0 = 1'b1; selout0 = 5'($urandom_range(0, 31));
            read1 = 1'b1; selout1 = 5'($urandom_range(0, 31));
            step();
        end
        set_idle();
        for (int i = 0; i < 32; i++) begin
            read0 = 1'b1; selout0 = 5'(i);
            step();
            chk("clr.zero", a_out0, 32'h0);
        end

        set_idle(); write = 1'b1; selin = 5'd4; inp = 32'hCAFEF00D; be = 4'hF;
        read0 = 1'b1; selout0 = 5'd4; read1 = 1'b1; selout1 = 5'd4; step();
        set_idle(); clr = 1'b1; step();
        clr = 1'b0;
        repeat (10) step();
        #2 reset = 1'b0;
        model_reset();
        #1 compare();
        @(negedge clk);
        reset = 1'b1;
        repeat (33) step();

        for (int n = 0; n < 3000; n++) begin
            EN    = ($urandom_range(0, 7) != 0);
            write = 1'($urandom_range(0, 1));
            selin = 5'($urandom_range(0, 31));
            inp   = $urandom;
            be    = 4'($urandom);
            read0 = 1'($urandom_range(0, 1));
            read1 = 1'($urandom_range(0, 1));
            selout0 = ($urandom_range(0, 3) == 0) ? selin : 5'($urandom_range(0, 31));
            selout1 = ($urandom_range(0, 3) == 0) ? selin : 5'($urandom_range(0, 31));
            clr   = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised successor to the single-port 32x32 register file.
- Provides one write port with byte enables and two independent read ports.
- Reads are registered on the rising edge, with a valid flag and write-to-read bypass.
- A hardware clear sequencer zeroes the array after reset or on request.
- Sits between instruction decode (read addresses) and writeback (write port) in the datapath.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; 2..256.
- AW, 5, address width; must satisfy 2**AW >= DEPTH.
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- EN  input  1  global enable; when 0, no write and no read capture occur.
- write  input  1  write request.
- selin  input  AW  write address.
- inp  input  WIDTH  write data.
- be  input  WIDTH/8  byte enables for the write; bit k covers inp[8k+7:8k].
- read0  input  1  read port 0 request.
- selout0  input  AW  read port 0 address.
- out0  output  WIDTH  read port 0 data (registered).
- valid0  output  1  out0 updated this cycle.
- read1  input  1  read port 1 request.
- selout1  input  AW  read port 1 address.
- out1  output  WIDTH  read port 1 data (registered).
- valid1  output  1  out1 updated this cycle.
- clr  input  1  request a full array clear (sampled in IDLE only).
- busy  output  1  clear sequence in progress; ports are locked out.

Behaviour:
- Reset (reset=0, asynchronous):
  - out0 = out1 = 0; valid0 = valid1 = 0; busy = 1.
  - FSM is forced to CLEAR with the clear pointer at 0.
  - Array contents are undefined until the CLEAR sequence completes.
- FSM states:
  - IDLE: normal operation. If clr=1, go to CLEAR with pointer 0 and busy=1 from the next cycle.
  - CLEAR: each cycle writes entry[ptr]=0 and increments ptr. When ptr==DEPTH-1 is written, return to IDLE; busy drops the cycle after the last entry is written.
  - Clear duration is exactly DEPTH cycles after reset release or after clr is sampled. Clear proceeds regardless of EN.
- During CLEAR:
  - write, read0, read1 and clr are ignored.
  - valid0 = valid1 = 0; out0/out1 hold their values.
- Write (IDLE, EN=1, write=1):
  - For each k with be[k]=1, entry[selin] byte k takes inp byte k. Bytes with be[k]=0 are unchanged. be=0 is a no-op.
  - Writes are ignored when ZERO_REG=1 and selin=0, or when selin >= DEPTH.
- Read port p (IDLE, EN=1, readp=1):
  - At the rising edge, outp takes entry[seloutp] and validp=1 for one cycle. Latency is 1 cycle from address to data.
  - readp=0 or EN=0: outp holds its value, validp=0.
  - seloutp >= DEPTH, or seloutp=0 with ZERO_REG=1, returns 0.
- Bypass:
  - A same-cycle write and read to the same valid, non-zero-hardwired address returns the merged new value: enabled bytes from inp, others from the old entry.
  - Bypass applies to both ports independently; both ports may read the same address.
- Simultaneous events:
  - clr asserted with write in IDLE: the write is performed that cycle, then CLEAR starts (the entry is zeroed later).
  - Reset asserted mid-CLEAR restarts the clear at pointer 0 after release.
- Widths: no arithmetic except the clear pointer, which is AW+1 bits wide to avoid wrap at DEPTH=2**AW.

Test Plan:
- Release reset, hold clr=0 -> busy=1 for exactly 32 cycles, then 0. Reading all 32 addresses gives 0 with valid pulses one cycle after each request.
- Write selin=5, inp=0xDEADBEEF, be=4'b1111, then be=4'b0010 with inp=0x00001200 -> read0 of selout0=5 returns 0xDEAD12EF one cycle later, valid0=1.
- Same cycle: write selin=7, inp=0xA5A5A5A5, be=4'b1111; read0 and read1 both at 7 -> out0=out1=0xA5A5A5A5 next cycle (bypass).
- ZERO_REG=1: write selin=0, inp=0xFFFFFFFF -> read0 at 0 returns 0. With DEPTH=20, AW=5: write to 25 is ignored and a read of 25 returns 0.
- Fill entries 1..31, pulse clr -> busy=1 for 32 cycles. Reads during busy give valid=0 and outputs held; afterwards every entry reads 0.
- Drop reset mid-CLEAR at pointer 10 -> outputs and valids go to 0 immediately. After release, busy lasts a full 32 cycles.
